// File: rtl/color_scan_if.sv
// Camera-writer, recognizer and shared frame-RAM signals seen by color_scan_ctrl.
// The controller takes the master modport; the peripherals (or a bench) take the slave modport.
interface color_scan_if;
  logic        cam_we;
  logic [14:0] cam_addr;
  logic        cam_done;
  logic [14:0] rec_addr;
  logic [7:0]  rec_color;
  logic        rec_done;
  logic        cap_enable;
  logic        rec_enable;
  logic [14:0] ram_addr;
  logic        ram_we;

  modport master (
    input  cam_we, cam_addr, cam_done, rec_addr, rec_color, rec_done,
    output cap_enable, rec_enable, ram_addr, ram_we
  );

  modport slave (
    output cam_we, cam_addr, cam_done, rec_addr, rec_color, rec_done,
    input  cap_enable, rec_enable, ram_addr, ram_we
  );
endinterface

// File: rtl/color_scan_ctrl.sv
// Frame-by-frame color scan sequencer: capture, recognize, debounce and publish a color,
// with a per-frame watchdog and a shared frame-RAM port mux.
module color_scan_ctrl #(
  parameter logic [14:0] BYTES_PER_FRAME = 15'd19200,
  parameter int unsigned CONFIRM_COUNT   = 3,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd2_000_000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         vsync_i,
  color_scan_if.master bus,
  output logic [14:0]  bytes_per_frame_o,
  output logic [7:0]   color_o,
  output logic         color_valid_o,
  output logic         busy_o,
  output logic         timeout_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ANALYZE = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;

  localparam logic [3:0] CONFIRM = 4'(CONFIRM_COUNT);

  logic [2:0]  state_q, state_d;
  logic [23:0] wd_q, wd_d;
  logic [1:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  lat_q, lat_d;
  logic [1:0]  color_q, color_d;
  logic        valid_q, valid_d;

  logic wd_hit;
  logic lat_is_color;

  assign wd_hit       = (wd_q == TIMEOUT_CYCLES - 24'd1);
  assign lat_is_color = (lat_q[7:2] == 6'd0) && (lat_q[1:0] != 2'd0);

  // A done strobe arriving in the watchdog's last cycle takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    color_d   = color_q;
    valid_d   = valid_q;
    timeout_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        wd_d = 24'd0;
        if (start_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        wd_d = wd_q + 24'd1;
        if (wd_hit) begin
          timeout_o = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = 4'd0;
          wd_d      = 24'd0;
        end else if (!start_i) begin
          state_d = S_IDLE;
        end else if (vsync_i) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        wd_d = wd_q + 24'd1;
        if (bus.cam_done) begin
          state_d = S_ANALYZE;
        end else if (wd_hit) begin
          timeout_o = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = 4'd0;
          wd_d      = 24'd0;
        end
      end

      S_ANALYZE: begin
        wd_d = wd_q + 24'd1;
        if (bus.rec_done) begin
          lat_d   = bus.rec_color;
          state_d = S_UPDATE;
        end else if (wd_hit) begin
          timeout_o = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = 4'd0;
          wd_d      = 24'd0;
        end
      end

      S_UPDATE: begin
        if (lat_is_color) begin
          if (lat_q[1:0] == cand_q) begin
            cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
          end else begin
            cand_d = lat_q[1:0];
            cnt_d  = 4'd1;
          end
        end else begin
          cand_d = 2'd0;
          cnt_d  = 4'd0;
        end
        if (cnt_d == CONFIRM) begin
          color_d = cand_d;
          valid_d = 1'b1;
        end
        wd_d    = 24'd0;
        state_d = start_i ? S_WAIT : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        wd_d    = 24'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wd_q    <= 24'd0;
      cand_q  <= 2'd0;
      cnt_q   <= 4'd0;
      lat_q   <= 8'd0;
      color_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  // Only the camera writer may ever write the frame RAM.
  always_comb begin
    bus.ram_addr = 15'd0;
    bus.ram_we   = 1'b0;
    if (state_q == S_CAPTURE) begin
      bus.ram_addr = bus.cam_addr;
      bus.ram_we   = bus.cam_we;
    end else if (state_q == S_ANALYZE) begin
      bus.ram_addr = bus.rec_addr;
    end
  end

  assign bus.cap_enable    = (state_q == S_CAPTURE);
  assign bus.rec_enable    = (state_q == S_ANALYZE);
  assign busy_o            = (state_q != S_IDLE);
  assign color_o           = {6'd0, color_q};
  assign color_valid_o     = valid_q;
  assign bytes_per_frame_o = BYTES_PER_FRAME;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Self-checking bench for color_scan_ctrl: vector table, hand-written corner sequences
// and randomized frames compared against a result-history reference model.
module tb_color_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        vsync;
  logic [14:0] bpf;
  logic [7:0]  color;
  logic        cvalid;
  logic        busy;
  logic        tmo;

  color_scan_if bus();

  color_scan_ctrl #(
    .BYTES_PER_FRAME(15'd19200),
    .CONFIRM_COUNT  (3),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .vsync_i          (vsync),
    .bus              (bus),
    .bytes_per_frame_o(bpf),
    .color_o          (color),
    .color_valid_o    (cvalid),
    .busy_o           (busy),
    .timeout_o        (tmo)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: the published color follows from the history of recognizer
  // results since the last reset or watchdog timeout.
  logic [7:0] hist[$];
  logic [7:0] mColor;
  logic       mValid;

  typedef struct {
    bit         doRst;
    logic [7:0] col;
    logic [7:0] expColor;
    logic       expValid;
  } vec_t;

  vec_t tbl[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    hist.delete();
    mColor = 8'h00;
    mValid = 1'b0;
  endtask

  task automatic modelUpdate(input logic [7:0] c);
    int n;
    hist.push_back(c);
    n = hist.size();
    if ((c == 8'h01 || c == 8'h02 || c == 8'h03) && n >= 3) begin
      if (hist[n-2] == c && hist[n-3] == c && (n == 3 || hist[n-4] != c)) begin
        mColor = c;
        mValid = 1'b1;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_color"}, color, mColor);
    checkOutput({tag, "_valid"}, cvalid, mValid);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    start = 1'b0;
    vsync = 1'b0;
    bus.cam_we    = 1'b0;
    bus.cam_addr  = 15'd0;
    bus.cam_done  = 1'b0;
    bus.rec_addr  = 15'd0;
    bus.rec_color = 8'd0;
    bus.rec_done  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    modelReset();
  endtask

  // One full frame from IDLE or WAIT_VSYNC; returns in the cycle after UPDATE.
  task automatic applyStimulus(input logic [7:0] col, input int camDelay, input int recDelay,
                               input bit dropStart);
    bit          capOk;
    logic [14:0] a;
    start = 1'b1;
    vsync = 1'b1;
    capOk = 1'b0;
    for (int i = 0; i < 6 && !capOk; i++) begin
      step();
      capOk = bus.cap_enable;
    end
    vsync = 1'b0;
    checkOutput("capEnter", capOk, 1);
    if (dropStart) start = 1'b0;
    a = 15'($urandom);
    bus.cam_we   = 1'b1;
    bus.cam_addr = a;
    #1;
    checkOutput("capAddr", bus.ram_addr, a);
    checkOutput("capWe", bus.ram_we, 1);
    repeat (camDelay) step();
    bus.cam_done = 1'b1;
    step();
    bus.cam_done = 1'b0;
    a = 15'($urandom);
    bus.rec_addr = a;
    #1;
    checkOutput("anaEn", {bus.cap_enable, bus.rec_enable}, 2'b01);
    checkOutput("anaWe", bus.ram_we, 0);
    checkOutput("anaAddr", bus.ram_addr, a);
    repeat (recDelay) step();
    bus.rec_color = col;
    bus.rec_done  = 1'b1;
    step();
    bus.rec_done  = 1'b0;
    bus.rec_color = 8'($urandom);
    #1;
    checkOutput("updBusy", busy, 1);
    checkOutput("updEn", {bus.cap_enable, bus.rec_enable}, 2'b00);
    step();
    bus.cam_we = 1'b0;
    modelUpdate(col);
    checkOutput("postBusy", busy, {31'd0, ~dropStart});
  endtask

  // Entered in the first WAIT_VSYNC cycle of a frame; no done strobe ever comes.
  task automatic timeoutTest();
    int cyc;
    int hit;
    cyc = 1;
    bus.cam_we   = 1'b1;
    bus.cam_addr = 15'h1234;
    #1;
    checkOutput("waitWe", bus.ram_we, 0);
    checkOutput("waitAddr", bus.ram_addr, 0);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    cyc = 2;
    checkOutput("capAddr1234", bus.ram_addr, 15'h1234);
    checkOutput("capWe1234", bus.ram_we, 1);
    hit = 0;
    for (int k = 0; k < 150; k++) begin
      if (tmo) begin
        hit = cyc;
        break;
      end
      step();
      cyc++;
    end
    checkOutput("toCycle", hit, 100);
    checkOutput("toCapHeld", bus.cap_enable, 1);
    step();
    checkOutput("toPulseEnd", tmo, 0);
    checkOutput("toIdle", busy, 0);
    checkOutput("toEnables", {bus.cap_enable, bus.rec_enable}, 2'b00);
    checkOutput("toRamWe", bus.ram_we, 0);
    bus.cam_we = 1'b0;
    hist.delete();
    checkModel("toKeep");
  endtask

  // Done strobe landing exactly on the watchdog's last cycle; entered in WAIT cycle 1.
  task automatic prioTest(input bit inAnalyze, input logic [7:0] col);
    int cyc;
    cyc = 1;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    cyc = 2;
    if (inAnalyze) begin
      bus.cam_done = 1'b1;
      step();
      bus.cam_done = 1'b0;
      cyc = 3;
    end
    while (cyc < 100) begin
      step();
      cyc++;
    end
    if (inAnalyze) begin
      bus.rec_color = col;
      bus.rec_done  = 1'b1;
    end else begin
      bus.cam_done = 1'b1;
    end
    #1;
    checkOutput("prioNoTimeout", tmo, 0);
    step();
    bus.cam_done = 1'b0;
    bus.rec_done = 1'b0;
    if (!inAnalyze) begin
      checkOutput("prioAnaEn", bus.rec_enable, 1);
      bus.rec_color = col;
      bus.rec_done  = 1'b1;
      step();
      bus.rec_done = 1'b0;
    end
    checkOutput("prioUpdBusy", busy, 1);
    checkOutput("prioUpdEn", {bus.cap_enable, bus.rec_enable}, 2'b00);
    step();
    modelUpdate(col);
    checkModel("prio");
  endtask

  task automatic resetInAnalyzeTest();
    if (!busy) begin
      start = 1'b1;
      step();
    end
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    bus.cam_done = 1'b1;
    step();
    bus.cam_done = 1'b0;
    checkOutput("raAnaEn", bus.rec_enable, 1);
    checkOutput("raPublished", (color != 8'h00), 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("raRecEn", bus.rec_enable, 0);
    checkOutput("raColor", color, 8'h00);
    checkOutput("raValid", cvalid, 0);
    checkOutput("raBusy", busy, 0);
    step();
    start = 1'b0;
    rst_n = 1'b1;
    modelReset();
    step();
    checkOutput("raNoResume", busy, 0);
  endtask

  initial begin
    logic [7:0] c;

    tbl[0]  = '{1'b1, 8'h02, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h02, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h02, 8'h02, 1'b1};
    tbl[3]  = '{1'b1, 8'h01, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h01, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h04, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h01, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h01, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'h01, 8'h01, 1'b1};
    tbl[9]  = '{1'b0, 8'hF0, 8'h01, 1'b1};
    tbl[10] = '{1'b0, 8'h03, 8'h01, 1'b1};
    tbl[11] = '{1'b0, 8'h03, 8'h01, 1'b1};
    tbl[12] = '{1'b0, 8'h03, 8'h03, 1'b1};
    tbl[13] = '{1'b0, 8'h03, 8'h03, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 8'h03, 1'b1};

    rst_n = 1'b0;
    start = 1'b1;
    vsync = 1'b1;
    bus.cam_we    = 1'b1;
    bus.cam_addr  = 15'h1234;
    bus.cam_done  = 1'b0;
    bus.rec_addr  = 15'h0555;
    bus.rec_color = 8'd0;
    bus.rec_done  = 1'b0;
    modelReset();
    #2;
    checkOutput("rstEnables", {bus.cap_enable, bus.rec_enable}, 2'b00);
    checkOutput("rstRamWe", bus.ram_we, 0);
    checkOutput("rstRamAddr", bus.ram_addr, 0);
    checkOutput("rstColor", color, 8'h00);
    checkOutput("rstValid", cvalid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstTimeout", tmo, 0);
    checkOutput("bytesPerFrame", bpf, 15'd19200);
    doReset();

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].doRst) doReset();
      applyStimulus(tbl[i].col, i % 3, (i + 1) % 4, 1'b0);
      modelReset();
      checkOutput($sformatf("vec%0d_color", i), color, tbl[i].expColor);
      checkOutput($sformatf("vec%0d_valid", i), cvalid, tbl[i].expValid);
    end

    // Rebuild model history to match the hardware after the table: published 3, no run.
    hist.delete();
    mColor = 8'h03;
    mValid = 1'b1;
    hist.push_back(8'h00);

    applyStimulus(8'h01, 1, 1, 1'b0);
    applyStimulus(8'h01, 2, 0, 1'b0);
    checkModel("preTo");
    timeoutTest();
    applyStimulus(8'h01, 0, 2, 1'b0);
    checkModel("postTo1");
    applyStimulus(8'h01, 1, 1, 1'b0);
    applyStimulus(8'h01, 1, 1, 1'b0);
    checkModel("postTo3");

    prioTest(1'b0, 8'h02);
    prioTest(1'b1, 8'h02);

    applyStimulus(8'h02, 2, 2, 1'b1);
    checkModel("dropStart");
    step();
    checkOutput("dropIdleStays", busy, 0);

    resetInAnalyzeTest();

    for (int f = 0; f < 30; f++) begin
      if (hist.size() > 0 && $urandom_range(0, 99) < 55) begin
        c = hist[hist.size() - 1];
      end else begin
        case ($urandom_range(0, 6))
          0:       c = 8'h01;
          1:       c = 8'h02;
          2:       c = 8'h03;
          3:       c = 8'h00;
          4:       c = 8'h04;
          5:       c = 8'hF0;
          default: c = 8'($urandom);
        endcase
      end
      applyStimulus(c, $urandom_range(0, 6), $urandom_range(0, 6), 1'b0);
      checkModel($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
